// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with output register plus one skid entry.
// Optional accept counter enabled by defining IMM_EXT_CNT_EN.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
`ifdef IMM_EXT_CNT_EN
  ,
  output logic [15:0]      acc_cnt
`endif
);

  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
  end

  function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                  input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   extend_imm = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b01:   extend_imm = sext;
      2'b10:   extend_imm = {imm, {(OUT_W-IN_W){1'b0}}};
      2'b11:   extend_imm = {sext[OUT_W-3:0], 2'b00};
      default: extend_imm = sext;
    endcase
  endfunction

  logic             or_valid_q, or_valid_d;
  logic [OUT_W-1:0] or_data_q,  or_data_d;
  logic [1:0]       or_mode_q,  or_mode_d;
  logic             sk_valid_q, sk_valid_d;
  logic [OUT_W-1:0] sk_data_q,  sk_data_d;
  logic [1:0]       sk_mode_q,  sk_mode_d;
  logic [OUT_W-1:0] ext_s;
  logic             accept_s;
  logic             take_s;

  assign ext_s    = extend_imm(in_imm, in_mode);
  assign accept_s = in_valid & ~sk_valid_q;
  assign take_s   = or_valid_q & out_ready;

  // Skid steering: SK only fills when OR is held, and drains into OR on take.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_mode_d  = or_mode_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    sk_mode_d  = sk_mode_q;
    if (!or_valid_q) begin
      if (accept_s) begin
        or_valid_d = 1'b1;
        or_data_d  = ext_s;
        or_mode_d  = in_mode;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (!sk_valid_q) begin
      if (take_s && accept_s) begin
        or_data_d = ext_s;
        or_mode_d = in_mode;
      end else if (take_s) begin
        or_valid_d = 1'b0;
      end else if (accept_s) begin
        sk_valid_d = 1'b1;
        sk_data_d  = ext_s;
        sk_mode_d  = in_mode;
      end else begin
        or_valid_d = 1'b1;
      end
    end else begin
      if (take_s) begin
        or_data_d  = sk_data_q;
        or_mode_d  = sk_mode_q;
        sk_valid_d = 1'b0;
      end else begin
        sk_valid_d = 1'b1;
      end
    end
  end

  // Storage registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid_q <= 1'b0;
      or_data_q  <= {OUT_W{1'b0}};
      or_mode_q  <= 2'b00;
      sk_valid_q <= 1'b0;
      sk_data_q  <= {OUT_W{1'b0}};
      sk_mode_q  <= 2'b00;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_mode_q  <= or_mode_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      sk_mode_q  <= sk_mode_d;
    end
  end

  assign in_ready  = ~sk_valid_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign out_mode  = or_mode_q;

`ifdef IMM_EXT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    if (accept_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Saturating accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign acc_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed, table-driven bench for imm_ext_pipe (default 16 -> 32 widths).
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
`ifdef IMM_EXT_CNT_EN
  logic [15:0] acc_cnt;
`endif

  int checks;
  int failures;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode)
`ifdef IMM_EXT_CNT_EN
    ,
    .acc_cnt  (acc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    vecs[0] = '{16'h8001, 2'b00, 32'h00008001};
    vecs[1] = '{16'h8001, 2'b01, 32'hFFFF8001};
    vecs[2] = '{16'h8001, 2'b10, 32'h80010000};
    vecs[3] = '{16'h8001, 2'b11, 32'hFFFE0004};
    vecs[4] = '{16'h7FFF, 2'b01, 32'h00007FFF};
    vecs[5] = '{16'h7FFF, 2'b11, 32'h0001FFFC};
    vecs[6] = '{16'hFFFF, 2'b00, 32'h0000FFFF};
    vecs[7] = '{16'h1234, 2'b10, 32'h12340000};
    vecs[8] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
    vecs[9] = '{16'h0000, 2'b01, 32'h00000000};

    rst = 1'b1; in_valid = 1'b0; in_imm = 16'h0; in_mode = 2'b00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_mode", {30'd0, out_mode}, 32'd0);
`ifdef IMM_EXT_CNT_EN
    chk("reset_acc_cnt", {16'd0, acc_cnt}, 32'd0);
`endif

    // Table sweep: one item at a time, result expected one edge after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_imm = vecs[i].imm; in_mode = vecs[i].mode;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      chk($sformatf("vec%0d_mode", i), {30'd0, out_mode}, {30'd0, vecs[i].mode});
      @(negedge clk);
      chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: A into OR, B into SK, then release.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'b00;
    @(negedge clk);
    chk("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
    in_imm = 16'h0002;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_data_a", out_data, 32'h1);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1; in_imm = 16'h0003;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_hold_data", out_data, 32'h1);
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_data_b", out_data, 32'h2);
    chk("bp_rel_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Streaming: 8 items back to back.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_imm = 16'h0100 + 16'(i); in_mode = 2'b00;
      chk($sformatf("stream%0d_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_data", i), out_data, 32'h00000100 + 32'(i));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Reset with both entries full and a new item presented.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0011; in_mode = 2'b01;
    @(negedge clk);
    in_imm = 16'h0022;
    @(negedge clk);
    chk("rstmid_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; in_imm = 16'h0055;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstmid_out_data", out_data, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_not_accepted", {31'd0, out_valid}, 32'd0);

`ifdef IMM_EXT_CNT_EN
    chk("cnt_after_rst", {16'd0, acc_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_imm = 16'(i); in_mode = 2'b00;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("cnt_five", {16'd0, acc_cnt}, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("cnt_cleared", {16'd0, acc_cnt}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 65534; i++) @(negedge clk);
    chk("cnt_near_sat", {16'd0, acc_cnt}, 32'h0000FFFE);
    for (int i = 0; i < 4; i++) @(negedge clk);
    in_valid = 1'b0;
    chk("cnt_saturated", {16'd0, acc_cnt}, 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
